// File: rtl/ddr_test_traffic_gen.sv
// DDR traffic generator/checker: writes a pattern into NUM_REGION regions,
// reads each region back and compares against a locally regenerated pattern.
module ddr_test_traffic_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter int unsigned NUM_REGION = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] REGION_STRIDE = ADDR_WIDTH'(32'h0010_0000),
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  test_en,
  input  logic [1:0]            test_mode,
  input  logic                  test_loop,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  wstart,
  input  logic                  wready,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [LEN_WIDTH-1:0]  wdata_len,
  output logic                  wdata_vld,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  rstart,
  input  logic                  rready,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [LEN_WIDTH-1:0]  rdata_len,
  input  logic                  rdata_vld,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  err_flag,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned REP = DATA_WIDTH / 32;
  localparam logic [1:0] MODE_INC = 2'd0;
  localparam logic [1:0] MODE_LFSR = 2'd1;
  localparam logic [1:0] MODE_WALK = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_DATA, WR_WAIT, RD_REQ, RD_DATA, NEXT, DONE
  } state_t;

  // First 32-bit word of a burst for the given seed.
  function automatic logic [31:0] seed_word(input logic [1:0] mode, input logic [31:0] s);
    case (mode)
      MODE_LFSR:  return s | 32'h1;
      MODE_CHECK: return 32'hAAAA_AAAA;
      default:    return s;
    endcase
  endfunction

  // Word for the following beat; CHECK alternates by inversion.
  function automatic logic [31:0] step_word(input logic [1:0] mode, input logic [31:0] w);
    case (mode)
      MODE_INC:   return w + 32'h1;
      MODE_LFSR:  return (w >> 1) ^ (w[0] ? LFSR_TAPS : 32'h0);
      MODE_CHECK: return ~w;
      default:    return w;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [1:0] mode,
                                                      input logic [31:0] w,
                                                      input logic [DATA_WIDTH-1:0] walk);
    return (mode == MODE_WALK) ? walk : {REP{w}};
  endfunction

  state_t                  state, state_nxt;
  logic                    test_en_q;
  logic [1:0]              mode_q;
  logic                    loop_q;
  logic [LEN_WIDTH-1:0]    len_q, beats_q, wbeat, rbeat;
  logic [7:0]              region;
  logic [ADDR_WIDTH-1:0]   region_addr;
  logic [31:0]             wword, rword, seed;
  logic [DATA_WIDTH-1:0]   wwalk, rwalk, rd_exp;
  logic                    start_rise, cfg_ok, last_region, miscmp;

  always_comb begin
    start_rise  = test_en & ~test_en_q;
    cfg_ok      = (burst_len != '0) && ((burst_len % LEN_WIDTH'(BEAT_BYTES)) == '0);
    last_region = (region == 8'(NUM_REGION - 1));
    seed        = {8'(pass_cnt), region, 16'h0};
    rd_exp      = beat_data(mode_q, rword, rwalk);
    miscmp      = rdata_vld && ((state != RD_DATA) || (rdata != rd_exp));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_rise && cfg_ok) state_nxt = WR_REQ;
      WR_REQ:  if (wready) state_nxt = WR_DATA;
      WR_DATA: if (wbeat == beats_q - LEN_WIDTH'(1)) state_nxt = WR_WAIT;
      WR_WAIT: if (wready) state_nxt = RD_REQ;
      RD_REQ:  if (rready) state_nxt = RD_DATA;
      RD_DATA: if (rdata_vld && (rbeat == beats_q - LEN_WIDTH'(1))) state_nxt = NEXT;
      NEXT: begin
        // A dropped test_en ends the run quietly once the current region is read back.
        if (!test_en)                    state_nxt = IDLE;
        else if (!last_region || loop_q) state_nxt = WR_REQ;
        else                             state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      test_en_q   <= 1'b1;
      mode_q      <= '0;
      loop_q      <= 1'b0;
      len_q       <= '0;
      beats_q     <= '0;
      wbeat       <= '0;
      rbeat       <= '0;
      region      <= '0;
      region_addr <= '0;
      wword       <= '0;
      rword       <= '0;
      wwalk       <= '0;
      rwalk       <= '0;
      wstart      <= 1'b0;
      waddr       <= '0;
      wdata_len   <= '0;
      wdata_vld   <= 1'b0;
      wdata       <= '0;
      rstart      <= 1'b0;
      raddr       <= '0;
      rdata_len   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      err_flag    <= 1'b0;
      pass_cnt    <= '0;
      err_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      test_en_q <= test_en;
      busy      <= (state_nxt != IDLE);
      cfg_err   <= (state == IDLE) && start_rise && !cfg_ok;
      wstart    <= (state == WR_REQ) && wready;
      rstart    <= (state == RD_REQ) && rready;
      wdata_vld <= (state == WR_DATA);
      if (state_nxt == DONE) done <= 1'b1;

      if ((state == WR_REQ) && wready) begin
        waddr     <= region_addr;
        wdata_len <= len_q;
        wword     <= seed_word(mode_q, seed);
        wwalk     <= DATA_WIDTH'(1);
        wbeat     <= '0;
      end
      if (state == WR_DATA) begin
        wdata <= beat_data(mode_q, wword, wwalk);
        wword <= step_word(mode_q, wword);
        wwalk <= {wwalk[DATA_WIDTH-2:0], wwalk[DATA_WIDTH-1]};
        wbeat <= wbeat + LEN_WIDTH'(1);
      end

      if ((state == RD_REQ) && rready) begin
        raddr     <= region_addr;
        rdata_len <= len_q;
        rword     <= seed_word(mode_q, seed);
        rwalk     <= DATA_WIDTH'(1);
        rbeat     <= '0;
      end
      // Checker generator advances only on received beats.
      if ((state == RD_DATA) && rdata_vld) begin
        rword <= step_word(mode_q, rword);
        rwalk <= {rwalk[DATA_WIDTH-2:0], rwalk[DATA_WIDTH-1]};
        rbeat <= rbeat + LEN_WIDTH'(1);
      end
      if (miscmp) begin
        err_flag <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_WIDTH'(1);
      end

      if (state == NEXT) begin
        if (!last_region) begin
          region      <= region + 8'd1;
          region_addr <= region_addr + REGION_STRIDE;
        end else begin
          region      <= '0;
          region_addr <= BASE_ADDR;
          if (pass_cnt != '1) pass_cnt <= pass_cnt + CNT_WIDTH'(1);
        end
      end

      if ((state == IDLE) && start_rise && cfg_ok) begin
        mode_q      <= test_mode;
        loop_q      <= test_loop;
        len_q       <= burst_len;
        beats_q     <= burst_len / LEN_WIDTH'(BEAT_BYTES);
        region      <= '0;
        region_addr <= BASE_ADDR;
        pass_cnt    <= '0;
        err_cnt     <= '0;
        err_flag    <= 1'b0;
        done        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddr_test_traffic_gen.sv
// Bench for ddr_test_traffic_gen: ideal DDR memory model with a write-data
// scoreboard, a table of run configurations and a few multi-cycle sequences.
module tb_ddr_test_traffic_gen;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] STRIDE = 32'h0010_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, test_en, test_loop;
  logic [1:0]  test_mode;
  logic [15:0] burst_len;
  logic        wstart, wready, wdata_vld, rstart, rready, rdata_vld;
  logic [31:0] waddr, raddr;
  logic [15:0] wdata_len, rdata_len, pass_cnt, err_cnt;
  logic [63:0] wdata, rdata;
  logic        busy, done, cfg_err, err_flag;

  ddr_test_traffic_gen #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .LEN_WIDTH(16), .NUM_REGION(4),
    .BASE_ADDR(BASE), .REGION_STRIDE(STRIDE), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rstn(rstn), .test_en(test_en), .test_mode(test_mode),
    .test_loop(test_loop), .burst_len(burst_len), .wstart(wstart),
    .wready(wready), .waddr(waddr), .wdata_len(wdata_len),
    .wdata_vld(wdata_vld), .wdata(wdata), .rstart(rstart), .rready(rready),
    .raddr(raddr), .rdata_len(rdata_len), .rdata_vld(rdata_vld),
    .rdata(rdata), .busy(busy), .done(done), .cfg_err(cfg_err),
    .err_flag(err_flag), .pass_cnt(pass_cnt), .err_cnt(err_cnt)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference pattern for beat b of a region, computed from scratch.
  function automatic logic [63:0] exp_data(input logic [1:0] mode, input int pass,
                                           input int region, input int b);
    logic [31:0] s, w;
    logic [63:0] one;
    s = {pass[7:0], region[7:0], 16'h0};
    one = 64'd1;
    case (mode)
      2'd0: w = s + 32'(b);
      2'd1: begin
        w = s | 32'h1;
        for (int i = 0; i < b; i++) w = {1'b0, w[31:1]} ^ (w[0] ? 32'h8020_0003 : 32'h0);
      end
      2'd2: return one << (b % 64);
      default: w = (b % 2 == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
    return {w, w};
  endfunction

  // Memory model state (written only by the model process).
  logic [63:0] mem [logic [31:0]];
  logic [63:0] expq [$];
  int          wstart_cnt = 0, rstart_cnt = 0, cfg_cnt = 0, busy_cycles = 0;
  int          mp = 0, mr = 0, w_got = 0, w_left = 0, r_left = 0, r_b = 0, r_delay = 0;
  bit          w_busy = 0, r_busy = 0, flip_pend = 0;
  logic [31:0] cur_waddr = 0, r_addr = 0;
  // Controls (written only by the main process).
  bit          w_block = 0, r_block = 0;
  int          flip_region = -1, flip_beat = 0;

  initial begin
    wready = 1'b1; rready = 1'b1; rdata_vld = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        expq.delete();
        w_busy = 0; r_busy = 0; r_left = 0; flip_pend = 0; mp = 0; mr = 0;
        wready = 1'b1; rready = 1'b1; rdata_vld = 1'b0;
        continue;
      end
      if (busy) busy_cycles++;
      else if (!wstart) begin mp = 0; mr = 0; end
      if (cfg_err) cfg_cnt++;
      if (wstart) begin
        wstart_cnt++;
        chk("waddr", waddr, BASE + 32'(mr) * STRIDE);
        chk("wdata_len", wdata_len, burst_len);
        w_left = int'(burst_len) / 8;
        for (int b = 0; b < w_left; b++) expq.push_back(exp_data(test_mode, mp, mr, b));
        w_got = 0; cur_waddr = waddr; w_busy = 1;
        mr++;
        if (mr == 4) begin mr = 0; mp++; end
      end
      if (wdata_vld) begin
        if (expq.size() == 0) begin
          n_checks++;
          $display("FAIL wdata_extra: beat %0h with nothing expected", wdata);
        end else chk("wdata", wdata, expq.pop_front());
        mem[cur_waddr + 32'(w_got) * 8] = wdata;
        w_got++;
        if (w_got == w_left) w_busy = 0;
      end
      wready = !w_block && !w_busy;
      if (rstart) begin
        rstart_cnt++;
        chk("raddr", raddr, cur_waddr);
        chk("rdata_len", rdata_len, burst_len);
        r_addr = raddr; r_left = int'(burst_len) / 8; r_b = 0; r_delay = 2; r_busy = 1;
      end
      if (flip_pend) begin
        chk("err_flag_after_flip", err_flag, 1'b1);
        chk("err_cnt_after_flip", err_cnt, 16'd1);
        flip_pend = 0;
      end
      rdata_vld = 1'b0;
      if (r_left > 0) begin
        if (r_delay > 0) r_delay--;
        else if ($urandom_range(0, 3) != 0) begin
          rdata_vld = 1'b1;
          rdata = mem.exists(r_addr + 32'(r_b) * 8) ? mem[r_addr + 32'(r_b) * 8] : '0;
          if (flip_region >= 0 && r_addr == BASE + 32'(flip_region) * STRIDE && r_b == flip_beat) begin
            rdata[5] = ~rdata[5];
            chk("err_flag_before_flip", err_flag, 1'b0);
            flip_pend = 1;
          end
          r_b++; r_left--;
        end
      end else r_busy = 0;
      rready = !r_block && !r_busy;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] len;
    bit          loop;
    int          flip_region;
    int          flip_beat;
    bit          exp_cfg;
    int          exp_pass;
    int          exp_err;
  } vec_t;

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 20000) begin @(negedge clk); t++; end
    if (busy) begin
      n_checks++;
      $display("FAIL %s_timeout: busy still %0b after %0d cycles", name, busy, t);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {wstart, wdata_vld, rstart, busy, done, cfg_err, err_flag}, '0);
    chk({tag, "_addr"}, {waddr, raddr}, '0);
    chk({tag, "_len"}, {wdata_len, rdata_len}, '0);
    chk({tag, "_wdata"}, wdata, '0);
    chk({tag, "_cnt"}, {pass_cnt, err_cnt}, '0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int ws0, rs0, cf0, bz0;
    test_mode = v.mode; burst_len = v.len; test_loop = v.loop;
    flip_region = v.flip_region; flip_beat = v.flip_beat;
    ws0 = wstart_cnt; rs0 = rstart_cnt; cf0 = cfg_cnt; bz0 = busy_cycles;
    test_en = 1'b1;
    repeat (2) @(negedge clk);
    if (v.exp_cfg) begin
      repeat (4) @(negedge clk);
      chk($sformatf("v%0d_cfg_err_pulses", idx), cfg_cnt - cf0, 1);
      chk($sformatf("v%0d_no_wstart", idx), wstart_cnt - ws0, 0);
      chk($sformatf("v%0d_busy_low", idx), busy_cycles - bz0, 0);
    end else begin
      chk($sformatf("v%0d_busy", idx), busy, 1'b1);
      wait_idle($sformatf("v%0d", idx));
      chk($sformatf("v%0d_pass_cnt", idx), pass_cnt, v.exp_pass);
      chk($sformatf("v%0d_err_cnt", idx), err_cnt, v.exp_err);
      chk($sformatf("v%0d_err_flag", idx), err_flag, v.exp_err != 0);
      chk($sformatf("v%0d_done", idx), done, 1'b1);
      chk($sformatf("v%0d_wr_cmds", idx), wstart_cnt - ws0, 4);
      chk($sformatf("v%0d_rd_cmds", idx), rstart_cnt - rs0, 4);
      chk($sformatf("v%0d_no_cfg_err", idx), cfg_cnt - cf0, 0);
    end
    test_en = 1'b0; flip_region = -1;
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs [8];
    int ws0, rs0, t;
    vecs[0] = '{2'd0, 16'd64,  1'b0, -1, 0, 1'b0, 1, 0};
    vecs[1] = '{2'd1, 16'd64,  1'b0, -1, 0, 1'b0, 1, 0};
    vecs[2] = '{2'd2, 16'd520, 1'b0, -1, 0, 1'b0, 1, 0};
    vecs[3] = '{2'd3, 16'd64,  1'b0, -1, 0, 1'b0, 1, 0};
    vecs[4] = '{2'd0, 16'd64,  1'b0,  2, 3, 1'b0, 1, 1};
    vecs[5] = '{2'd0, 16'd12,  1'b0, -1, 0, 1'b1, 0, 0};
    vecs[6] = '{2'd0, 16'd0,   1'b0, -1, 0, 1'b1, 0, 0};
    vecs[7] = '{2'd3, 16'd8,   1'b0, -1, 0, 1'b0, 1, 0};

    rstn = 1'b0; test_en = 1'b0; test_mode = 2'd0; test_loop = 1'b0; burst_len = 16'd64;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Looping LFSR run, stopped after at least three passes.
    test_mode = 2'd1; test_loop = 1'b1; burst_len = 16'd64;
    ws0 = wstart_cnt; rs0 = rstart_cnt;
    test_en = 1'b1;
    t = 0;
    while (pass_cnt < 3 && t < 20000) begin @(negedge clk); t++; end
    repeat (30) @(negedge clk);
    test_en = 1'b0;
    wait_idle("loop");
    chk("loop_pass_ge3", pass_cnt >= 16'd3, 1'b1);
    chk("loop_pass_cnt", pass_cnt, (wstart_cnt - ws0) / 4);
    chk("loop_rd_per_wr", rstart_cnt - rs0, wstart_cnt - ws0);
    chk("loop_err_cnt", err_cnt, 0);
    chk("loop_done_low", done, 1'b0);
    test_loop = 1'b0;
    @(negedge clk);

    // Command requests held off by wready / rready.
    test_mode = 2'd0; burst_len = 16'd64;
    ws0 = wstart_cnt; rs0 = rstart_cnt;
    w_block = 1; r_block = 1;
    test_en = 1'b1;
    repeat (50) @(negedge clk);
    chk("hold_no_wstart", wstart_cnt - ws0, 0);
    chk("hold_busy", busy, 1'b1);
    w_block = 0;
    repeat (20) @(negedge clk);
    chk("hold_one_wstart", wstart_cnt - ws0, 1);
    chk("hold_no_rstart", rstart_cnt - rs0, 0);
    repeat (30) @(negedge clk);
    chk("hold_still_no_rstart", rstart_cnt - rs0, 0);
    r_block = 0;
    repeat (5) @(negedge clk);
    chk("hold_one_rstart", rstart_cnt - rs0, 1);
    chk("hold_wstart_once", wstart_cnt - ws0, 1);
    wait_idle("hold");
    chk("hold_pass_cnt", pass_cnt, 1);
    chk("hold_err_cnt", err_cnt, 0);
    test_en = 1'b0;
    @(negedge clk);

    // Reset during the fourth write beat of region 1.
    test_en = 1'b1;
    t = 0;
    while (!(mr == 2 && w_got >= 4) && t < 2000) begin @(negedge clk); t++; end
    chk("pre_reset_wdata_vld", wdata_vld, 1'b1);
    rstn = 1'b0;
    @(negedge clk);
    chk_zero("midrun_reset");
    rstn = 1'b1;
    @(negedge clk);
    chk_zero("after_reset");
    ws0 = wstart_cnt; t = busy_cycles;
    repeat (20) @(negedge clk);
    chk("no_reissue_wstart", wstart_cnt - ws0, 0);
    chk("no_reissue_busy", busy_cycles - t, 0);
    test_en = 1'b0;
    @(negedge clk);
    run_vec(vecs[0], 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
